// File: rtl/bm_stats_pkg.sv
// Shared widths, FSM encoding and min/max preset constants for the
// Gaussian sample statistics accumulator.
package bm_stats_pkg;

    localparam int SAMPLE_W = 20;
    localparam int SUM_W    = 48;
    localparam int SQ_W     = 64;
    localparam int CNT_W    = 16;
    localparam int PROD_W   = 2 * SAMPLE_W - 1;

    typedef enum logic [2:0] {
        WARM,
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic signed [SAMPLE_W-1:0] MIN_INIT = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] MAX_INIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

endpackage

// File: rtl/square_20.sv
// Registered signed 20x20 squarer, one cycle latency, unsigned 39-bit result.
// Interchangeable with the vendor multiplier primitive.
module square_20
    import bm_stats_pkg::*;
(
    input  logic                       clk,
    input  logic                       nreset,
    input  logic signed [SAMPLE_W-1:0] a,
    output logic        [PROD_W-1:0]   sq
);

    // The square of a 20-bit value fits 39 bits (largest is 2^38), so the
    // truncated product keeps every significant bit.
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] prod;

    assign a_ext = {{(PROD_W-SAMPLE_W){a[SAMPLE_W-1]}}, a};
    assign prod  = a_ext * a_ext;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sq <= '0;
        end else begin
            sq <= $unsigned(prod);
        end
    end

endmodule

// File: rtl/gauss_stats_acc.sv
// Captures N consecutive Gaussian samples after a warm-up window and reports
// sum, sum of squares, minimum and maximum with a one-cycle done pulse.
module gauss_stats_acc
    import bm_stats_pkg::*;
#(
    parameter int WARMUP = 16
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [31:0]         sample_in,
    input  logic                start,
    input  logic [CNT_W-1:0]    n_samples,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    sum_out,
    output logic [SQ_W-1:0]     sumsq_out,
    output logic [SAMPLE_W-1:0] min_out,
    output logic [SAMPLE_W-1:0] max_out
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 2);

    state_t                     state, state_nx;
    logic [CNT_W-1:0]           warm_cnt, run_cnt, n_lat;
    logic                       drain_cnt, n_zero;
    logic                       accept, cap_d, busy_d, ready_d, fin_d;
    logic                       fin_p, clr_p;
    logic                       vld_p0, vld_p1;
    logic signed [SAMPLE_W-1:0] s_p0;
    logic signed [SUM_W-1:0]    sum_p1;
    logic signed [SAMPLE_W-1:0] min_p1, max_p1;
    logic        [PROD_W-1:0]   sq_p1;
    logic        [SQ_W-1:0]     sumsq_p2;
    logic                       unused_hi;

    assign unused_hi = ^sample_in[31:SAMPLE_W];

    function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [SAMPLE_W-1:0] s);
        return {{(SUM_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    assign accept = start && ready && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= WARM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WARM:  if (warm_cnt == WARM_LAST) state_nx = IDLE;
            IDLE,
            DONE:  if (accept) state_nx = (n_samples == '0) ? DRAIN : RUN;
            RUN:   if (run_cnt == n_lat - CNT_W'(1)) state_nx = DRAIN;
            DRAIN: if (drain_cnt) state_nx = DONE;
            default: state_nx = WARM;
        endcase
    end

    always_comb begin
        cap_d   = (state == RUN);
        busy_d  = (state == RUN) || (state == DRAIN);
        ready_d = (state == IDLE) || (state == DONE);
        fin_d   = (state == DRAIN) && drain_cnt;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            warm_cnt  <= '0;
            run_cnt   <= '0;
            n_lat     <= '0;
            n_zero    <= 1'b0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            fin_p     <= 1'b0;
            clr_p     <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (state == WARM) warm_cnt <= warm_cnt + CNT_W'(1);
            if (accept) begin
                run_cnt <= '0;
                n_lat   <= n_samples;
                n_zero  <= (n_samples == '0);
            end else if (state == RUN) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            busy      <= busy_d;
            ready     <= ready_d;
            fin_p     <= fin_d;
            clr_p     <= accept;
            done      <= fin_p;
        end
    end

    // stage p0: raw sample capture, one per RUN cycle
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s_p0   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= cap_d;
            if (cap_d) s_p0 <= sample_in[SAMPLE_W-1:0];
        end
    end

    square_20 u_square (
        .clk    (clk),
        .nreset (nreset),
        .a      (s_p0),
        .sq     (sq_p1)
    );

    // stage p1: running sum and extrema, alongside the squarer register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sum_p1 <= '0;
            min_p1 <= '0;
            max_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (accept) begin
                sum_p1 <= '0;
                min_p1 <= MIN_INIT;
                max_p1 <= MAX_INIT;
            end else if (vld_p0) begin
                sum_p1 <= sum_p1 + sext_sum(s_p0);
                if (s_p0 < min_p1) min_p1 <= s_p0;
                if (s_p0 > max_p1) max_p1 <= s_p0;
            end
        end
    end

    // stage p2: sum of squares
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sumsq_p2 <= '0;
        end else if (accept) begin
            sumsq_p2 <= '0;
        end else if (vld_p1) begin
            sumsq_p2 <= sumsq_p2 + SQ_W'(sq_p1);
        end
    end

    // Result registers only ever show zero or final values; an empty run
    // reports zero extrema instead of the presets.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sum_out   <= '0;
            sumsq_out <= '0;
            min_out   <= '0;
            max_out   <= '0;
        end else if (clr_p) begin
            sum_out   <= '0;
            sumsq_out <= '0;
            min_out   <= '0;
            max_out   <= '0;
        end else if (fin_p) begin
            sum_out   <= sum_p1;
            sumsq_out <= sumsq_p2;
            min_out   <= n_zero ? '0 : min_p1;
            max_out   <= n_zero ? '0 : max_p1;
        end
    end

endmodule

// File: tb/tb_gauss_stats_acc.sv
// Scoreboard bench for gauss_stats_acc: expected statistics are queued at
// start and compared when done pulses.
module tb_gauss_stats_acc;

    localparam int WARMUP = 16;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] sample_in = '0;
    logic        start = 1'b0;
    logic [15:0] n_samples = '0;
    logic        ready, busy, done;
    logic [47:0] sum_out;
    logic [63:0] sumsq_out;
    logic [19:0] min_out, max_out;

    typedef struct {
        logic [47:0] sum;
        logic [63:0] sumsq;
        logic [19:0] mn;
        logic [19:0] mx;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_vec = 0;
    int   n_err = 0;

    gauss_stats_acc #(.WARMUP(WARMUP)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .sample_in (sample_in),
        .start     (start),
        .n_samples (n_samples),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .sumsq_out (sumsq_out),
        .min_out   (min_out),
        .max_out   (max_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Pop and compare whenever the DUT reports completion.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sum", 64'(sum_out), 64'(e.sum));
                chk("sumsq", sumsq_out, e.sumsq);
                chk("min", 64'(min_out), 64'(e.mn));
                chk("max", 64'(max_out), 64'(e.mx));
            end
        end
    end

    function automatic logic [31:0] pat(input int mode, input int i);
        case (mode)
            0: return 32'h0000_1000;
            1: return (i % 2 == 0) ? 32'h0000_1000 : 32'hFFFF_F000;
            3: return 32'hFFF8_0000;
            default: return $urandom();
        endcase
    endfunction

    // Issue one accepted start at the next edge, drive N samples, and check
    // edge-1 clearing and done latency. Returns in the done cycle.
    task automatic run(input int n, input int mode, input int poke_edge);
        logic [31:0]        smp[$];
        logic signed [19:0] s;
        longint             acc, acc2;
        int                 mn, mx, ecnt, done_edge;
        exp_t               e;
        acc = 0; acc2 = 0; mn = 524287; mx = -524288;
        for (int i = 0; i < n; i++) begin
            smp.push_back(pat(mode, i));
            s = smp[i][19:0];
            acc  += longint'(s);
            acc2 += longint'(s) * longint'(s);
            if (int'(s) < mn) mn = int'(s);
            if (int'(s) > mx) mx = int'(s);
        end
        if (n == 0) begin mn = 0; mx = 0; end
        e.sum = acc[47:0]; e.sumsq = acc2; e.mn = mn[19:0]; e.mx = mx[19:0];
        sb_q.push_back(e);
        last_exp = e;
        start = 1'b1;
        n_samples = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        n_samples = 16'($urandom());
        ecnt = 0;
        done_edge = -1;
        while (done_edge < 0 && ecnt < n + 12) begin
            sample_in = (ecnt < n) ? smp[ecnt] : $urandom();
            if (ecnt + 1 == poke_edge) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            ecnt++;
            if (ecnt == 1) begin
                chk("clr_sum", 64'(sum_out), 64'd0);
                chk("clr_sumsq", sumsq_out, 64'd0);
                chk("run_ready", 64'(ready), 64'd0);
                chk("run_busy", 64'(busy), 64'd1);
            end
            if (done) done_edge = ecnt;
        end
        chk("done_lat", 64'(done_edge), 64'(n + 3));
        if (done_edge >= 0) begin
            chk("done_ready", 64'(ready), 64'd1);
            chk("done_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic warm_check(input bit poke);
        for (int e = 1; e <= WARMUP; e++) begin
            if (poke && e == 3) begin
                start = 1'b1;
                n_samples = 16'd4;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("warm_ready", 64'(ready), 64'(e >= WARMUP));
        end
        chk("warm_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum_out), 64'd0);
        chk("rst_minmax", 64'({min_out, max_out}), 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        warm_check(1'b1);
        repeat (3) @(posedge clk);
        #1;

        run(4, 0, 0);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("hold_sum", 64'(sum_out), 64'(last_exp.sum));
        chk("hold_sumsq", sumsq_out, last_exp.sumsq);

        run(4, 1, 0);
        run(16, 2, 0);
        run(0, 0, 0);
        run(8, 2, 4);
        run(1, 2, 0);
        run(65535, 3, 0);

        // Mid-run asynchronous reset: everything clears, no done pulse.
        @(posedge clk); #1;
        start = 1'b1;
        n_samples = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        nreset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_sum", 64'(sum_out), 64'd0);
        chk("arst_sumsq", sumsq_out, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        warm_check(1'b0);
        run(5, 2, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
